// File: rtl/div_pkg.sv
// Shared constants and helpers for the signed 8-bit divider and its BCD readout stage.
package div_pkg;
  localparam int DIV_W = 8;
  localparam int BCD_W = 12;

  localparam logic [4:0] ST_LOAD_Q = 5'd0;
  localparam logic [4:0] ST_LOAD_R = 5'd9;
  localparam logic [4:0] ST_DONE   = 5'd18;
  localparam logic [4:0] ST_CLEAR  = 5'd19;

  // -128 maps to 0x80, which is the correct unsigned magnitude
  function automatic logic [DIV_W-1:0] mag8(input logic [DIV_W-1:0] x);
    return x[DIV_W-1] ? (~x + 1'b1) : x;
  endfunction
endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to each BCD nibble >= 5, then shift left by one.
module bcd_dabble_step (
  input  logic [19:0] d,
  output logic [19:0] q
);
  logic [19:0] adj;

  always_comb begin
    adj = d;
    for (int n = 0; n < 3; n++) begin
      if (d[8+4*n +: 4] >= 4'd5)
        adj[8+4*n +: 4] = d[8+4*n +: 4] + 4'd3;
    end
    q = {adj[18:0], 1'b0};
  end
endmodule

// File: rtl/div_result_bcd_8bit.sv
// Converts divider quotient/remainder to sign + 3-digit BCD, one bit per start-qualified clock.
module div_result_bcd_8bit
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_sig,
  input  logic [DIV_W-1:0] quotient,
  input  logic [DIV_W-1:0] reminder,
  output logic             done_sig,
  output logic             q_sign,
  output logic [BCD_W-1:0] q_bcd,
  output logic             r_sign,
  output logic [BCD_W-1:0] r_bcd
);
  logic [4:0]       i;
  logic [19:0]      sr;
  logic [19:0]      sr_step;
  logic [DIV_W-1:0] r_op;
  logic             q_sgn_t;
  logic             r_sgn_t;
  logic [BCD_W-1:0] q_tmp;

  bcd_dabble_step u_step (
    .d (sr),
    .q (sr_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i        <= '0;
      sr       <= '0;
      r_op     <= '0;
      q_sgn_t  <= 1'b0;
      r_sgn_t  <= 1'b0;
      q_tmp    <= '0;
      done_sig <= 1'b0;
      q_sign   <= 1'b0;
      q_bcd    <= '0;
      r_sign   <= 1'b0;
      r_bcd    <= '0;
    end else if (start_sig) begin
      // start_sig low freezes everything; no abort path
      case (i)
        ST_LOAD_Q: begin
          r_op    <= reminder;
          q_sgn_t <= quotient[DIV_W-1];
          sr      <= {12'd0, mag8(quotient)};
          i       <= i + 5'd1;
        end
        ST_LOAD_R: begin
          q_tmp   <= sr[19:8];
          r_sgn_t <= r_op[DIV_W-1];
          sr      <= {12'd0, mag8(r_op)};
          i       <= i + 5'd1;
        end
        ST_DONE: begin
          q_bcd    <= q_tmp;
          q_sign   <= q_sgn_t;
          r_bcd    <= sr[19:8];
          r_sign   <= r_sgn_t;
          done_sig <= 1'b1;
          i        <= i + 5'd1;
        end
        ST_CLEAR: begin
          done_sig <= 1'b0;
          i        <= '0;
        end
        default: begin
          if (i < ST_DONE) begin
            sr <= sr_step;
            i  <= i + 5'd1;
          end else begin
            i <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_result_bcd_8bit.sv
// Directed bench for div_result_bcd_8bit: latency, sign/magnitude, freeze, reset and back-to-back runs.
module tb_div_result_bcd_8bit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_sig;
  logic [7:0]  quotient;
  logic [7:0]  reminder;
  logic        done_sig;
  logic        q_sign;
  logic [11:0] q_bcd;
  logic        r_sign;
  logic [11:0] r_bcd;

  int errors = 0;
  int checks = 0;

  div_result_bcd_8bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_sig (start_sig),
    .quotient  (quotient),
    .reminder  (reminder),
    .done_sig  (done_sig),
    .q_sign    (q_sign),
    .q_bcd     (q_bcd),
    .r_sign    (r_sign),
    .r_bcd     (r_bcd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string name, input logic es, input logic [11:0] eq,
                              input logic ers, input logic [11:0] er);
    checks++;
    if ({q_sign, q_bcd, r_sign, r_bcd} !== {es, eq, ers, er}) begin
      errors++;
      $display("FAIL %s: got q=%0b/%h r=%0b/%h, want q=%0b/%h r=%0b/%h",
               name, q_sign, q_bcd, r_sign, r_bcd, es, eq, ers, er);
    end
  endtask

  // Start at a negedge, expect done_sig exactly after the 19th edge, then one CLEAR edge, drop start.
  task automatic run_conv(input string name, input logic [7:0] q, input logic [7:0] r,
                          input logic es, input logic [11:0] eq, input logic ers, input logic [11:0] er);
    int early;
    early = 0;
    @(negedge clk);
    quotient = q; reminder = r; start_sig = 1'b1;
    for (int n = 1; n <= 19; n++) begin
      tick();
      if (n == 1) begin quotient = 8'h5A; reminder = 8'hA5; end
      if (n < 19 && done_sig !== 1'b0) early++;
    end
    checks++;
    if (early != 0 || done_sig !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency: early=%0d done=%0b, want early=0 done=1", name, early, done_sig);
    end
    check_result(name, es, eq, ers, er);
    tick();
    checks++;
    if (done_sig !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: done=%0b after clear edge, want 0", name, done_sig);
    end
    @(negedge clk);
    start_sig = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_sig = 1'b0; quotient = 8'h00; reminder = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({done_sig, q_sign, q_bcd, r_sign, r_bcd} !== 27'd0) begin
      errors++;
      $display("FAIL reset_state: got %h, want 0", {done_sig, q_sign, q_bcd, r_sign, r_bcd});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_signs();
    run_conv("pos_25_2",   8'h19, 8'h02, 1'b0, 12'h025, 1'b0, 12'h002);
    run_conv("neg_13_1",   8'hF3, 8'hFF, 1'b1, 12'h013, 1'b1, 12'h001);
    run_conv("min_128_127", 8'h80, 8'h7F, 1'b1, 12'h128, 1'b0, 12'h127);
  endtask

  task automatic test_freeze();
    int early;
    early = 0;
    @(negedge clk);
    quotient = 8'h19; reminder = 8'hF6; start_sig = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      tick();
      if (n == 5) begin
        @(negedge clk);
        start_sig = 1'b0; quotient = 8'h63; reminder = 8'h01;
      end
      if (n == 10) begin
        @(negedge clk);
        start_sig = 1'b1;
      end
      if (n < 24 && done_sig !== 1'b0) early++;
    end
    checks++;
    if (early != 0 || done_sig !== 1'b1) begin
      errors++;
      $display("FAIL freeze_latency: early=%0d done=%0b, want early=0 done=1", early, done_sig);
    end
    check_result("freeze_vals", 1'b0, 12'h025, 1'b1, 12'h010);
    tick();
    @(negedge clk);
    start_sig = 1'b0;
  endtask

  task automatic test_reset_mid();
    int early;
    early = 0;
    @(negedge clk);
    quotient = 8'h2A; reminder = 8'h09; start_sig = 1'b1;
    repeat (12) tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({done_sig, q_sign, q_bcd, r_sign, r_bcd} !== 27'd0) begin
      errors++;
      $display("FAIL reset_mid: got %h, want 0", {done_sig, q_sign, q_bcd, r_sign, r_bcd});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 19; n++) begin
      tick();
      if (n < 19 && done_sig !== 1'b0) early++;
    end
    checks++;
    if (early != 0 || done_sig !== 1'b1) begin
      errors++;
      $display("FAIL reset_rerun_latency: early=%0d done=%0b, want early=0 done=1", early, done_sig);
    end
    check_result("reset_rerun", 1'b0, 12'h042, 1'b0, 12'h009);
    tick();
    @(negedge clk);
    start_sig = 1'b0;
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    @(negedge clk);
    quotient = 8'h0C; reminder = 8'h03; start_sig = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 1) begin quotient = 8'h00; reminder = 8'h00; end
      if (done_sig === 1'b1) pulses++;
      if (n == 19) begin
        checks++;
        if (done_sig !== 1'b1) begin
          errors++;
          $display("FAIL b2b_first_done: done=%0b, want 1", done_sig);
        end
        check_result("b2b_first", 1'b0, 12'h012, 1'b0, 12'h003);
      end
      if (n == 39) begin
        checks++;
        if (done_sig !== 1'b1) begin
          errors++;
          $display("FAIL b2b_second_done: done=%0b, want 1", done_sig);
        end
        check_result("b2b_zero", 1'b0, 12'h000, 1'b0, 12'h000);
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL b2b_pulse_count: got %0d, want 2", pulses);
    end
    @(negedge clk);
    start_sig = 1'b0;
  endtask

  initial begin
    test_reset();
    test_signs();
    test_freeze();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, want completion");
    $fatal(1);
  end
endmodule
